cle_key_sequencer: RTL

- Host-side initiator for the serial-key responder GAL in the 0x1xxx bus window.
- Each step issues one read strobe: SSER low, BA13=0, BA12=1, BR_W=1, with a 4-bit challenge nibble on BA7..BA4. The responder advances its 6-bit state on that clock edge.
- On that same edge the block samples the responder's SDRD bit and shifts it into a response word.
- Sits between the boot/firmware controller (start/challenge) and the shared bus arbiter (req/grant).

---
 rtl/cle_key_pkg.sv | 27 ++
 rtl/cle_step_timer.sv | 32 +++
 rtl/cle_key_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cle_key_pkg.sv
// Shared definitions for the serial-key sequencer.
//   state_e  : sequencer FSM states
//   BA13_* / BA12_* : bus window select levels when idle / when owning the bus
//   TMR_W    : width of the SETUP/GAP step timer
package cle_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETUP,
        STROBE,
        GAP,
        DONE
    } state_e;

    // Bus levels when the sequencer does not own the bus
    localparam logic BA13_IDLE = 1'b1;
    localparam logic BA12_IDLE = 1'b0;

    // Bus levels that select the responder window (0x1xxx)
    localparam logic BA13_SEL  = 1'b0;
    localparam logic BA12_SEL  = 1'b1;

    // Wide enough for GAP_CYCLES up to 15 and generous SETUP_CYCLES values
    localparam int TMR_W = 8;

endpackage

// File: rtl/cle_step_timer.sv
// Loadable down-counter shared by the SETUP and GAP phases.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : remaining cycles minus one for the phase being entered
//   zero     : counter has reached zero (phase ends this cycle)
module cle_step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cle_key_sequencer.sv
// Host-side initiator for the serial-key responder in the 0x1xxx bus window.
// For every step it drives a challenge nibble on BA7..BA4, issues one
// single-cycle SSER strobe (read), and shifts the sampled SDRD bit into the
// response word.
//
// Optional build macro: CLE_KEY_CHECK_EN adds the expected input and the
// match output (response compared with expected when the sequence ends).
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, challenge  : sequence request and NUM_STEPS nibbles (step 0 in [3:0])
//   busy, done        : sequence in progress / one-cycle completion pulse
//   response          : bit k = SDRD sampled at step k, held until next start
//   bus_req, bus_gnt  : arbiter handshake
//   ba13, ba12, ba_nib, br_w, sser_n : responder bus signals
//   sdrd              : responder serial data
//   expected, match   : (CLE_KEY_CHECK_EN only) reference word and compare result
module cle_key_sequencer
    import cle_key_pkg::*;
#(
    parameter int NUM_STEPS    = 16,
    parameter int GAP_CYCLES   = 2,
    parameter int SETUP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NUM_STEPS-1:0] challenge,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_STEPS-1:0]   response,
    output logic                   bus_req,
    input  logic                   bus_gnt,
    output logic                   ba13,
    output logic                   ba12,
    output logic [3:0]             ba_nib,
    output logic                   br_w,
    output logic                   sser_n,
    input  logic                   sdrd
`ifdef CLE_KEY_CHECK_EN
    ,
    input  logic [NUM_STEPS-1:0]   expected,
    output logic                   match
`endif
);

    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_STEPS - 1);
    localparam logic [TMR_W-1:0]  SETUP_LOAD = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e                 state_q, state_nxt;
    logic [STEP_W-1:0]      step_q, step_nxt, step_inc;
    logic                   busy_q, busy_nxt;
    logic                   done_q, done_nxt;
    logic [NUM_STEPS-1:0]   resp_q, resp_nxt;
    logic                   bus_req_q, bus_req_nxt;
    logic                   ba13_q, ba13_nxt;
    logic                   ba12_q, ba12_nxt;
    logic [3:0]             nib_q, nib_nxt;
    logic                   sser_n_q, sser_n_nxt;
    logic [4*NUM_STEPS-1:0] chal_q;
    logic                   chal_cap;
    logic                   tmr_load;
    logic [TMR_W-1:0]       tmr_val;
    logic                   tmr_zero;
`ifdef CLE_KEY_CHECK_EN
    logic [NUM_STEPS-1:0]   exp_q;
    logic                   match_q, match_nxt;
`endif

    function automatic logic [3:0] nib_at(input logic [4*NUM_STEPS-1:0] c,
                                          input logic [STEP_W-1:0]      idx);
        logic [4*NUM_STEPS-1:0] sh;
        sh = c >> {idx, 2'b00};
        return sh[3:0];
    endfunction

    assign step_inc = step_q + 1'b1;

    cle_step_timer #(
        .W        (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Challenge/expected words are plain data: captured on an accepted start
    always_ff @(posedge clk) begin
        if (chal_cap) begin
            chal_q <= challenge;
`ifdef CLE_KEY_CHECK_EN
            exp_q  <= expected;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= '0;
            bus_req_q <= 1'b0;
            ba13_q    <= BA13_IDLE;
            ba12_q    <= BA12_IDLE;
            nib_q     <= 4'h0;
            sser_n_q  <= 1'b1;
`ifdef CLE_KEY_CHECK_EN
            match_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_nxt;
            step_q    <= step_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            resp_q    <= resp_nxt;
            bus_req_q <= bus_req_nxt;
            ba13_q    <= ba13_nxt;
            ba12_q    <= ba12_nxt;
            nib_q     <= nib_nxt;
            sser_n_q  <= sser_n_nxt;
`ifdef CLE_KEY_CHECK_EN
            match_q   <= match_nxt;
`endif
        end
    end

    // Next-state and next-output logic; every output is the registered
    // image of the value computed here for the state being entered.
    always_comb begin
        state_nxt   = state_q;
        step_nxt    = step_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        resp_nxt    = resp_q;
        bus_req_nxt = bus_req_q;
        ba13_nxt    = ba13_q;
        ba12_nxt    = ba12_q;
        nib_nxt     = nib_q;
        sser_n_nxt  = 1'b1;
        chal_cap    = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
`ifdef CLE_KEY_CHECK_EN
        match_nxt   = match_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt   = REQ;
                    step_nxt    = '0;
                    busy_nxt    = 1'b1;
                    bus_req_nxt = 1'b1;
                    resp_nxt    = '0;
                    chal_cap    = 1'b1;
`ifdef CLE_KEY_CHECK_EN
                    match_nxt   = 1'b0;
`endif
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_nxt = SETUP;
                    ba13_nxt  = BA13_SEL;
                    ba12_nxt  = BA12_SEL;
                    nib_nxt   = nib_at(chal_q, step_q);
                    tmr_load  = 1'b1;
                    tmr_val   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_nxt  = STROBE;
                    sser_n_nxt = 1'b0;
                end
            end
            STROBE: begin
                // The responder advances on this same edge; its SDRD is valid now
                resp_nxt[step_q] = sdrd;
                if (step_q == LAST_STEP) begin
                    state_nxt   = DONE;
                    done_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    bus_req_nxt = 1'b0;
                    ba13_nxt    = BA13_IDLE;
                    ba12_nxt    = BA12_IDLE;
                    nib_nxt     = 4'h0;
`ifdef CLE_KEY_CHECK_EN
                    match_nxt   = (resp_nxt == exp_q);
`endif
                end else begin
                    step_nxt = step_inc;
                    tmr_load = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        // Address stays on the previous nibble through the gap
                        state_nxt = GAP;
                        tmr_val   = GAP_LOAD;
                    end else begin
                        state_nxt = SETUP;
                        nib_nxt   = nib_at(chal_q, step_inc);
                        tmr_val   = SETUP_LOAD;
                    end
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    state_nxt = SETUP;
                    nib_nxt   = nib_at(chal_q, step_q);
                    tmr_load  = 1'b1;
                    tmr_val   = SETUP_LOAD;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign response = resp_q;
    assign bus_req  = bus_req_q;
    assign ba13     = ba13_q;
    assign ba12     = ba12_q;
    assign ba_nib   = nib_q;
    assign br_w     = 1'b1;
    assign sser_n   = sser_n_q;
`ifdef CLE_KEY_CHECK_EN
    assign match    = match_q;
`endif

endmodule
